// File: rtl/sap1_control_sequencer.sv
//==============================================================================
// Module   : sap1_control_sequencer
// Brief    : SAP-1 T-state ring and opcode decoder driving the datapath controls.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sap1_control_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] ir_opcode,
    input  logic       b_zero,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic [2:0] alu_op,
    output logic       out_load,
    output logic [2:0] t_state,
    output logic       instr_done,
    output logic       halted,
    output logic       div_err
);

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        HALT = 3'd7
    } state_t;

    localparam logic [3:0] c_op_lda = 4'h0;
    localparam logic [3:0] c_op_div = 4'h4;
    localparam logic [3:0] c_op_out = 4'hE;
    localparam logic [3:0] c_op_hlt = 4'hF;

    state_t state_q, state_d;
    logic   halted_q, halted_d;
    logic   div_err_q, div_err_d;

    logic w_is_lda;
    logic w_is_alu;

    assign w_is_lda = (ir_opcode == c_op_lda);
    assign w_is_alu = (ir_opcode[3] == 1'b0) && (ir_opcode != c_op_lda);

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        div_err_d  = div_err_q;
        pc_inc     = 1'b0;
        pc_out     = 1'b0;
        mar_load   = 1'b0;
        ram_out    = 1'b0;
        ir_load    = 1'b0;
        ir_out     = 1'b0;
        a_load     = 1'b0;
        a_out      = 1'b0;
        b_load     = 1'b0;
        alu_out    = 1'b0;
        alu_op     = 3'b000;
        out_load   = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            T1: begin
                if (run) begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                    state_d  = T2;
                end
            end
            T2: begin
                pc_inc  = 1'b1;
                state_d = T3;
            end
            T3: begin
                ram_out = 1'b1;
                ir_load = 1'b1;
                state_d = T4;
            end
            T4: begin
                if (w_is_lda || w_is_alu) begin
                    ir_out   = 1'b1;
                    mar_load = 1'b1;
                    state_d  = T5;
                end else if (ir_opcode == c_op_out) begin
                    a_out      = 1'b1;
                    out_load   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = T1;
                end else if (ir_opcode == c_op_hlt) begin
                    instr_done = 1'b1;
                    halted_d   = 1'b1;
                    state_d    = HALT;
                end else begin
                    instr_done = 1'b1;
                    state_d    = T1;
                end
            end
            T5: begin
                if (w_is_alu) begin
                    ram_out = 1'b1;
                    b_load  = 1'b1;
                    state_d = T6;
                end else begin
                    // LDA; any other opcode here only if IR changed mid-instruction
                    ram_out    = w_is_lda;
                    a_load     = w_is_lda;
                    instr_done = 1'b1;
                    state_d    = T1;
                end
            end
            T6: begin
                instr_done = 1'b1;
                state_d    = T1;
                if (w_is_alu) begin
                    // Divide by zero leaves A untouched and latches the sticky error
                    if ((ir_opcode == c_op_div) && b_zero) begin
                        div_err_d = 1'b1;
                    end else begin
                        alu_op  = ir_opcode[2:0];
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = T1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= T1;
            halted_q  <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            div_err_q <= div_err_d;
        end
    end

    assign t_state = state_q;
    assign halted  = halted_q;
    assign div_err = div_err_q;

endmodule

`default_nettype wire
